// File: rtl/jtag_seq_pkg.sv
// Shared definitions for the JTAG shift sequencer: op codes, FSM encoding,
// and the TMS walk patterns used to move the TAP between Run-Test/Idle and the shift states.
package jtag_seq_pkg;

    localparam int CNT_W = 7;

    typedef enum logic [1:0] {
        OP_TAP_RESET = 2'b00,
        OP_SHIFT_IR  = 2'b01,
        OP_SHIFT_DR  = 2'b10,
        OP_RUN_IDLE  = 2'b11
    } jtag_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_HDR   = 3'd2,
        S_SHIFT = 3'd3,
        S_TAIL  = 3'd4,
        S_RUN   = 3'd5,
        S_RSP   = 3'd6
    } seq_state_e;

    // Patterns are read LSB first: bit k is the TMS value of the k-th TCK of the segment.
    localparam logic [CNT_W-1:0] RESET_TCKS = 7'd6;
    localparam logic [CNT_W-1:0] RESET_ONES = 7'd5;
    localparam logic [3:0]       HDR_DR_TMS = 4'b0001;
    localparam logic [CNT_W-1:0] HDR_DR_LEN = 7'd3;
    localparam logic [3:0]       HDR_IR_TMS = 4'b0011;
    localparam logic [CNT_W-1:0] HDR_IR_LEN = 7'd4;
    localparam logic [3:0]       TAIL_TMS   = 4'b0001;
    localparam logic [CNT_W-1:0] TAIL_LEN   = 7'd2;

    function automatic logic pat_bit(input logic [3:0] pat, input logic [CNT_W-1:0] idx);
        logic [3:0] sh;
        sh = pat >> idx;
        return sh[0];
    endfunction

    function automatic logic [3:0] hdr_tms(input jtag_op_e op);
        if (op == OP_SHIFT_IR) begin
            return HDR_IR_TMS;
        end else begin
            return HDR_DR_TMS;
        end
    endfunction

    function automatic logic [CNT_W-1:0] hdr_len(input jtag_op_e op);
        if (op == OP_SHIFT_IR) begin
            return HDR_IR_LEN;
        end else begin
            return HDR_DR_LEN;
        end
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: CLK_DIV clk low then CLK_DIV clk high while enabled; parked low otherwise.
// CLK_DIV must be at least 1.
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic trst,
    input  logic en,
    output logic tck,
    output logic fall_stb,
    output logic rise_stb
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_r;
    logic             tck_r;
    logic             wrap_s;

    assign wrap_s   = (div_cnt_r == DIV_W'(CLK_DIV - 1));
    assign rise_stb = en && wrap_s && !tck_r;
    assign fall_stb = en && wrap_s && tck_r;
    assign tck      = tck_r;

    // Phase counter and TCK level; restarting from a low phase whenever re-enabled.
    always_ff @(posedge clk or negedge trst) begin
        if (!trst) begin
            div_cnt_r <= '0;
            tck_r     <= 1'b0;
        end else if (!en) begin
            div_cnt_r <= '0;
            tck_r     <= 1'b0;
        end else if (wrap_s) begin
            div_cnt_r <= '0;
            tck_r     <= ~tck_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
            tck_r     <= tck_r;
        end
    end

endmodule

// File: rtl/jtag_shift_sequencer.sv
// Command-driven JTAG master: walks the TAP through reset, IR/DR scans and idle
// clocking, capturing TDO into a right-aligned response word.
module jtag_shift_sequencer
    import jtag_seq_pkg::*;
#(
    parameter int MAX_BITS = 32,
    parameter int CLK_DIV  = 2
) (
    input  logic                clk,
    input  logic                trst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [5:0]          cmd_len,
    input  logic [MAX_BITS-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [MAX_BITS-1:0] rsp_data,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo,
    output logic                busy
);

    seq_state_e          state_r, state_n;
    jtag_op_e            op_r, op_n;
    logic [CNT_W-1:0]    idx_r, idx_n, len_r, len_n;
    logic [CNT_W-1:0]    eff_len_s, seg_len_s;
    logic                seg_last_s;
    logic [MAX_BITS-1:0] data_r, data_n, mask_r, mask_n, rsp_data_r;
    logic                tms_r, tms_n, tdi_r, tdi_n;
    logic                rsp_valid_r, busy_r, cmd_ready_r;
    logic                accept_s, en_s, fall_stb_s, rise_stb_s;

    assign accept_s = cmd_valid && cmd_ready_r && (state_r == S_IDLE);
    assign en_s     = (state_r == S_RESET) || (state_r == S_HDR) || (state_r == S_SHIFT) ||
                      (state_r == S_TAIL)  || (state_r == S_RUN);

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk      (clk),
        .trst     (trst),
        .en       (en_s),
        .tck      (tck),
        .fall_stb (fall_stb_s),
        .rise_stb (rise_stb_s)
    );

    // Shift lengths above the data width are clamped; idle counts pass through unchanged.
    always_comb begin
        eff_len_s = CNT_W'(cmd_len);
        if (((cmd_op == OP_SHIFT_IR) || (cmd_op == OP_SHIFT_DR)) &&
            ({26'd0, cmd_len} > 32'(MAX_BITS))) begin
            eff_len_s = CNT_W'(MAX_BITS);
        end else begin
            eff_len_s = CNT_W'(cmd_len);
        end
    end

    // Next-state logic: segments advance on TCK falling strobes, then the upcoming
    // TCK's TMS/TDI are derived so they change exactly at the start of a low phase.
    always_comb begin
        state_n   = state_r;
        op_n      = op_r;
        idx_n     = idx_r;
        len_n     = len_r;
        data_n    = data_r;
        mask_n    = mask_r;
        tms_n     = tms_r;
        tdi_n     = 1'b0;
        seg_len_s = '0;

        case (state_r)
            S_RESET: seg_len_s = RESET_TCKS;
            S_HDR:   seg_len_s = hdr_len(op_r);
            S_SHIFT: seg_len_s = len_r;
            S_TAIL:  seg_len_s = TAIL_LEN;
            S_RUN:   seg_len_s = len_r;
            default: seg_len_s = '0;
        endcase
        seg_last_s = (idx_r == seg_len_s - CNT_W'(1));

        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    op_n   = jtag_op_e'(cmd_op);
                    len_n  = eff_len_s;
                    data_n = cmd_data;
                    mask_n = MAX_BITS'(1);
                    idx_n  = '0;
                    case (op_n)
                        OP_TAP_RESET: state_n = S_RESET;
                        OP_RUN_IDLE:  state_n = (eff_len_s == '0) ? S_RSP : S_RUN;
                        default:      state_n = (eff_len_s == '0) ? S_RSP : S_HDR;
                    endcase
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_RESET, S_HDR, S_SHIFT, S_TAIL, S_RUN: begin
                if (fall_stb_s && seg_last_s) begin
                    idx_n = '0;
                    case (state_r)
                        S_HDR:   state_n = S_SHIFT;
                        S_SHIFT: state_n = S_TAIL;
                        default: state_n = S_RSP;
                    endcase
                end else if (fall_stb_s) begin
                    idx_n = idx_r + CNT_W'(1);
                    if (state_r == S_SHIFT) begin
                        data_n = data_r >> 1;
                        mask_n = mask_r << 1;
                    end else begin
                        data_n = data_r;
                    end
                end else begin
                    state_n = state_r;
                end
            end
            S_RSP: begin
                if (rsp_valid_r && rsp_ready) begin
                    state_n = S_IDLE;
                end else begin
                    state_n = S_RSP;
                end
            end
            default: state_n = S_IDLE;
        endcase

        case (state_n)
            S_RESET: tms_n = (idx_n < RESET_ONES);
            S_HDR:   tms_n = pat_bit(hdr_tms(op_n), idx_n);
            S_SHIFT: begin
                tms_n = (idx_n == len_n - CNT_W'(1));
                tdi_n = data_n[0];
            end
            S_TAIL:  tms_n = pat_bit(TAIL_TMS, idx_n);
            S_RUN:   tms_n = 1'b0;
            default: tms_n = tms_r;
        endcase
    end

    // Sequencer state, pin registers and the response handshake.
    always_ff @(posedge clk or negedge trst) begin
        if (!trst) begin
            state_r     <= S_IDLE;
            op_r        <= OP_TAP_RESET;
            idx_r       <= '0;
            len_r       <= '0;
            data_r      <= '0;
            mask_r      <= '0;
            tms_r       <= 1'b1;
            tdi_r       <= 1'b0;
            rsp_data_r  <= '0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            op_r        <= op_n;
            idx_r       <= idx_n;
            len_r       <= len_n;
            data_r      <= data_n;
            mask_r      <= mask_n;
            tms_r       <= tms_n;
            tdi_r       <= tdi_n;
            busy_r      <= (state_n != S_IDLE);
            cmd_ready_r <= (state_n == S_IDLE);
            if (accept_s) begin
                rsp_data_r <= '0;
            end else if ((state_r == S_SHIFT) && rise_stb_s && tdo) begin
                rsp_data_r <= rsp_data_r | mask_r;
            end else begin
                rsp_data_r <= rsp_data_r;
            end
            if ((state_r == S_RSP) && !rsp_valid_r) begin
                rsp_valid_r <= 1'b1;
            end else if (rsp_valid_r && rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end else begin
                rsp_valid_r <= rsp_valid_r;
            end
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign tms       = tms_r;
    assign tdi       = tdi_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_jtag_shift_sequencer.sv
// Directed bench for jtag_shift_sequencer with a behavioural TAP controller on the pins.
module tb_jtag_shift_sequencer;

    localparam int MAX_BITS = 32;
    localparam int CLK_DIV  = 2;

    logic                clk = 1'b0;
    logic                trst = 1'b1;
    logic                cmd_valid = 1'b0;
    logic                rsp_ready = 1'b0;
    logic [1:0]          cmd_op = 2'b00;
    logic [5:0]          cmd_len = 6'd0;
    logic [MAX_BITS-1:0] cmd_data = '0;
    logic                cmd_ready, rsp_valid, tck, tms, tdi, tdo, busy;
    logic [MAX_BITS-1:0] rsp_data;

    int n_tests = 0;
    int n_fail  = 0;

    jtag_shift_sequencer #(.MAX_BITS(MAX_BITS), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .trst(trst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef enum int {
        T_TLR, T_RTI, T_SEL_DR, T_CAP_DR, T_SHIFT_DR, T_EXIT1_DR, T_PAUSE_DR, T_EXIT2_DR,
        T_UPD_DR, T_SEL_IR, T_CAP_IR, T_SHIFT_IR, T_EXIT1_IR, T_PAUSE_IR, T_EXIT2_IR, T_UPD_IR
    } tap_e;

    tap_e       tap_st = T_TLR;
    logic [4:0] ir_sr = 5'd0;
    int         tck_total = 0;
    int         upir_cnt = 0;
    logic       tms_log [0:4095];
    logic       tdi_log [0:4095];

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            T_TLR:      return m ? T_TLR      : T_RTI;
            T_RTI:      return m ? T_SEL_DR   : T_RTI;
            T_SEL_DR:   return m ? T_SEL_IR   : T_CAP_DR;
            T_CAP_DR:   return m ? T_EXIT1_DR : T_SHIFT_DR;
            T_SHIFT_DR: return m ? T_EXIT1_DR : T_SHIFT_DR;
            T_EXIT1_DR: return m ? T_UPD_DR   : T_PAUSE_DR;
            T_PAUSE_DR: return m ? T_EXIT2_DR : T_PAUSE_DR;
            T_EXIT2_DR: return m ? T_UPD_DR   : T_SHIFT_DR;
            T_UPD_DR:   return m ? T_SEL_DR   : T_RTI;
            T_SEL_IR:   return m ? T_TLR      : T_CAP_IR;
            T_CAP_IR:   return m ? T_EXIT1_IR : T_SHIFT_IR;
            T_SHIFT_IR: return m ? T_EXIT1_IR : T_SHIFT_IR;
            T_EXIT1_IR: return m ? T_UPD_IR   : T_PAUSE_IR;
            T_PAUSE_IR: return m ? T_EXIT2_IR : T_PAUSE_IR;
            T_EXIT2_IR: return m ? T_UPD_IR   : T_SHIFT_IR;
            default:    return m ? T_SEL_DR   : T_RTI;
        endcase
    endfunction

    // DR is a straight loopback; IR captures 5'b00001 and shifts toward TDO.
    assign tdo = (tap_st == T_SHIFT_DR) ? tdi : ((tap_st == T_SHIFT_IR) ? ir_sr[0] : 1'b0);

    always @(posedge tck) begin
        if (tck_total < 4096) begin
            tms_log[tck_total] = tms;
            tdi_log[tck_total] = tdi;
        end
        tck_total = tck_total + 1;
        if (tap_st == T_CAP_IR) ir_sr = 5'b00001;
        else if (tap_st == T_SHIFT_IR) ir_sr = {tdi, ir_sr[4:1]};
        tap_st = tap_next(tap_st, tms);
        if (tap_st == T_UPD_IR) upir_cnt = upir_cnt + 1;
    end

    function automatic logic [63:0] log_bits(input bit use_tms, input int start, input int n);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < n; i++) begin
            if (start + i < 4096) v[i] = use_tms ? tms_log[start + i] : tdi_log[start + i];
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offers a command and returns at the negedge following the accepting posedge.
    task automatic send_cmd(input logic [1:0] op, input logic [5:0] len,
                            input logic [31:0] data, output int base);
        int guard;
        guard = 0;
        @(negedge clk);
        cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 64'(cmd_ready), 64'd1);
        base = tck_total;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_post_hs"}, {61'd0, rsp_valid, cmd_ready, busy}, 64'b010);
    endtask

    initial begin
        int base, lat, t0, guard;
        bit ok;

        #2 trst = 1'b0;
        #3;
        check("reset_pins", {58'd0, tck, tms, tdi, cmd_ready, rsp_valid, busy}, 64'b010000);
        check("reset_rsp_data", 64'(rsp_data), 64'd0);
        @(negedge clk); trst = 1'b1;
        #1 check("ready_before_edge", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check("ready_after_edge", 64'(cmd_ready), 64'd1);

        // TAP_RESET
        send_cmd(2'b00, 6'd0, 32'h0, base);
        wait_rsp(lat);
        check("rst_latency", 64'(lat), 64'd25);
        check("rst_tcks", 64'(tck_total - base), 64'd6);
        check("rst_tms", log_bits(1'b1, base, 6), 64'b011111);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_data", 64'(rsp_data), 64'd0);
        check("rst_tap_rti", 64'(tap_st == T_RTI), 64'd1);
        finish_rsp("rst");

        // SHIFT_IR len 5
        t0 = upir_cnt;
        send_cmd(2'b01, 6'd5, 32'h1A, base);
        wait_rsp(lat);
        check("ir_latency", 64'(lat), 64'd45);
        check("ir_tcks", 64'(tck_total - base), 64'd11);
        check("ir_data", 64'(rsp_data), 64'h1);
        check("ir_upir", 64'(upir_cnt - t0), 64'd1);
        check("ir_tdi", log_bits(1'b0, base + 4, 5), 64'h1A);
        check("ir_tap_rti", 64'(tap_st == T_RTI), 64'd1);
        finish_rsp("ir");

        // SHIFT_DR len 32 loopback
        send_cmd(2'b10, 6'd32, 32'hDEADBEEF, base);
        wait_rsp(lat);
        check("dr32_latency", 64'(lat), 64'd149);
        check("dr32_tcks", 64'(tck_total - base), 64'd37);
        check("dr32_data", 64'(rsp_data), 64'hDEADBEEF);
        check("dr32_tdi", log_bits(1'b0, base + 3, 32), 64'hDEADBEEF);
        check("dr32_tms", log_bits(1'b1, base, 37), 64'h0000_000C_0000_0001);
        finish_rsp("dr32");

        // SHIFT_DR len 0
        send_cmd(2'b10, 6'd0, 32'hFFFFFFFF, base);
        wait_rsp(lat);
        check("dr0_latency", 64'(lat), 64'd1);
        check("dr0_tcks", 64'(tck_total - base), 64'd0);
        check("dr0_data", 64'(rsp_data), 64'd0);
        finish_rsp("dr0");

        // SHIFT_DR len 40 clamps to 32
        send_cmd(2'b10, 6'd40, 32'h12345678, base);
        wait_rsp(lat);
        check("dr40_latency", 64'(lat), 64'd149);
        check("dr40_tcks", 64'(tck_total - base), 64'd37);
        check("dr40_data", 64'(rsp_data), 64'h12345678);
        finish_rsp("dr40");

        // RUN_IDLE len 3
        send_cmd(2'b11, 6'd3, 32'hFFFFFFFF, base);
        wait_rsp(lat);
        check("run3_latency", 64'(lat), 64'd13);
        check("run3_tcks", 64'(tck_total - base), 64'd3);
        check("run3_pins", {log_bits(1'b1, base, 3)[31:0], log_bits(1'b0, base, 3)[31:0]}, 64'd0);
        check("run3_data", 64'(rsp_data), 64'd0);
        finish_rsp("run3");

        // RUN_IDLE len 0
        send_cmd(2'b11, 6'd0, 32'h0, base);
        wait_rsp(lat);
        check("run0_latency", 64'(lat), 64'd1);
        check("run0_tcks", 64'(tck_total - base), 64'd0);
        finish_rsp("run0");

        // Response back-pressure with a competing command offered
        send_cmd(2'b10, 6'd8, 32'hA5, base);
        wait_rsp(lat);
        check("stall_latency", 64'(lat), 64'd53);
        check("stall_data", 64'(rsp_data), 64'hA5);
        cmd_op = 2'b00; cmd_valid = 1'b1;
        t0 = tck_total;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(rsp_valid === 1'b1 && rsp_data === 32'hA5 && cmd_ready === 1'b0 && busy === 1'b1))
                ok = 1'b0;
        end
        check("stall_stable", 64'(ok), 64'd1);
        check("stall_tcks", 64'(tck_total - t0), 64'd0);
        cmd_valid = 1'b0;
        finish_rsp("stall");

        // Reset during the high phase of DR bit 7
        send_cmd(2'b10, 6'd16, 32'h00FF, base);
        guard = 0;
        while (!((tck_total - base) == 11 && tck === 1'b1) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("midrst_reached", 64'(guard < 500), 64'd1);
        check("midrst_pre_pins", {62'd0, tms, tdi}, 64'b01);
        #1 trst = 1'b0;
        #1 check("midrst_pins", {59'd0, tck, tms, tdi, rsp_valid, busy}, 64'b01000);
        @(negedge clk);
        @(negedge clk);
        trst = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) ok = 1'b0;
        end
        check("midrst_no_rsp", 64'(ok), 64'd1);
        check("midrst_ready", 64'(cmd_ready), 64'd1);

        send_cmd(2'b00, 6'd0, 32'h0, base);
        wait_rsp(lat);
        check("rst2_latency", 64'(lat), 64'd25);
        check("rst2_tcks", 64'(tck_total - base), 64'd6);
        check("rst2_tap_rti", 64'(tap_st == T_RTI), 64'd1);
        finish_rsp("rst2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_shift_sequencer.md
JTAG_SHIFT_SEQUENCER -- requirements
Module: jtag_shift_sequencer

Interface
REQ-001 Parameter MAX_BITS, default 32: maximum shift length in bits.
REQ-002 Parameter CLK_DIV, default 2: clk cycles per TCK half-period; values below 1 are illegal.
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 trst  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  sequencer can accept a command.
REQ-007 cmd_op  in  2  operation: 00 TAP_RESET, 01 SHIFT_IR, 10 SHIFT_DR, 11 RUN_IDLE.
REQ-008 cmd_len  in  6  bits to shift (SHIFT_*), or TCK count (RUN_IDLE).
REQ-009 cmd_data  in  MAX_BITS  TDI payload, LSB shifted first.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  response consumed.
REQ-012 rsp_data  out  MAX_BITS  captured TDO bits, right-aligned.
REQ-013 tck, tms, tdi  out  1 each  JTAG pins driven to the TAP.
REQ-014 tdo  in  1  JTAG data from the TAP.
REQ-015 busy  out  1  high from command accept until response handshake completes.

Function
REQ-016 States: S_IDLE, S_RESET, S_HDR, S_SHIFT, S_TAIL, S_RUN, S_RSP.
REQ-017 cmd_ready is high only in S_IDLE; a command is accepted on cmd_valid & cmd_ready, and op/len/data are latched.
REQ-018 TCK cycle is CLK_DIV clk low followed by CLK_DIV clk high; tck idles low outside commands.
REQ-019 tms and tdi change only at the start of a TCK low phase.
REQ-020 tdo is sampled on the clk edge where tck goes 0->1.
REQ-021 TAP_RESET: 5 TCK with TMS=1, then 1 TCK with TMS=0, for 6 TCK total, ending in Run-Test/Idle.
REQ-022 SHIFT_DR header: TMS 1,0,0.
REQ-023 SHIFT_IR header: TMS 1,1,0,0.
REQ-024 Shift phase: N TCK; bit i drives tdi=cmd_data[i]; TMS=0 for bits 0..N-2 and TMS=1 on bit N-1.
REQ-025 Shift tail: TMS 1,0, returning the TAP to Run-Test/Idle.
REQ-026 Shift TCK totals: DR = N+5; IR = N+6.
REQ-027 TDO is captured only on the N shift-phase rising edges; the bit on edge i goes to rsp_data[i], and rsp_data[MAX_BITS-1:N] = 0.
REQ-028 RUN_IDLE: cmd_len TCK with TMS=0 and tdi=0; rsp_data=0.
REQ-029 Every command produces exactly one response.
REQ-030 Response timing: rsp_valid rises 1 clk after the last TCK high phase ends; accept-to-rsp_valid = 2*CLK_DIV*TCKs + 1 clk.
REQ-031 rsp_valid and rsp_data are held stable until rsp_ready; S_RSP then goes to S_IDLE on the next clk.
REQ-032 SHIFT_* with cmd_len=0: no TCK, rsp_valid the next clk, rsp_data=0.
REQ-033 RUN_IDLE with cmd_len=0: no TCK, rsp_valid the next clk, rsp_data=0.
REQ-034 cmd_len > MAX_BITS for SHIFT_* is clamped to MAX_BITS.
REQ-035 Only TAP_RESET presents more than 2 consecutive TMS=1 TCKs, so the TAP 5-ones timeout is never hit unintentionally.
REQ-036 cmd_valid during busy is ignored (not accepted); rsp_ready outside S_RSP has no effect.
REQ-037 tdi=0 whenever not in the shift phase.

Reset
REQ-038 On trst low, immediately (asynchronously): state S_IDLE, tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0, and all counters zero.
REQ-039 cmd_ready rises on the first clk edge after trst deasserts.
REQ-040 Reset mid-command abandons the command with no response; TAP state is then undefined and software issues TAP_RESET.

Structure
REQ-041 Package jtag_seq_pkg holds the op codes, state encoding, and header/tail TMS patterns and lengths.
REQ-042 Sub-module jtag_tck_gen (CLK_DIV divider) outputs tck, fall_stb and rise_stb; it is enabled only during command TCK activity.

Verification
REQ-043 CLK_DIV=2, TAP_RESET -> 6 TCK; TMS=1,1,1,1,1,0; rsp_valid at clk 25 after accept; rsp_data=0.
REQ-044 SHIFT_IR len=5, data=0x1A, TAP model returns 0x01 -> 11 TCK; TAP passes through UPIR; rsp_data=0x00000001.
REQ-045 SHIFT_DR len=32, data=0xDEADBEEF, TAP in bypass-loopback -> 37 TCK; tdi stream LSB first; rsp_data=0xDEADBEEF.
REQ-046 SHIFT_DR len=0, then len=40 -> first: no TCK, rsp next clk; second: clamped to 32, 37 TCK.
REQ-047 rsp_ready held low 10 clk with cmd_valid high -> rsp_valid/rsp_data stable, cmd_ready=0, no TCK.
REQ-048 trst pulse during SHIFT_DR bit 7 -> tck=0, tms=1, rsp_valid=0 immediately; next TAP_RESET completes normally.
